// File: rtl/uart_conf_loader.sv
//------------------------------------------------------------------------------
// uart_conf_loader: UART packet receiver committing PAR_NUM params atomically.
// Optional: UART_PARITY_EN selects 8E1 framing (default 8N1).  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_conf_loader #(
  parameter int         BAUD_DIV     = 434,
  parameter int         PAR_NUM      = 5,
  parameter int         PAR_W        = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_data,
  output logic [PAR_NUM*PAR_W-1:0] par,
  output logic                     par_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int BPP      = (PAR_W + 7) / 8;
  localparam int NBYTES   = PAR_NUM * BPP;
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int IW       = $clog2(NBYTES + 1);
  localparam int TW       = $clog2(TO_LIMIT + 1);

  localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PAR, B_STOP} byte_state_t;
  typedef enum logic [1:0] {P_WAIT, P_PAYLOAD, P_CHECK} pkt_state_t;

  byte_state_t          bstate;
  pkt_state_t           pstate;
  logic [1:0]           sync_ff;
  logic                 rx;
  logic                 rx_prev;
  logic [CW-1:0]        cnt;
  logic [2:0]           bitn;
  logic [7:0]           shreg;
  logic                 line_err;
  logic                 stop_sample;
  logic                 byte_ok;
  logic                 byte_bad;
  logic [IW-1:0]        idx;
  logic [7:0]           csum;
  logic [NBYTES*8-1:0]  stage;
  logic [TW-1:0]        tcnt;
  logic                 timeout;

  assign rx = sync_ff[1];

`ifdef UART_PARITY_EN
  logic perr;
  assign line_err = perr;
`else
  assign line_err = 1'b0;
`endif

  assign stop_sample = (bstate == B_STOP) && (cnt == C_LAST);
  assign byte_ok     = stop_sample && rx && !line_err;
  assign byte_bad    = stop_sample && (!rx || line_err);
  assign timeout     = (tcnt == TW'(TO_LIMIT));

  // Byte deserialiser; sync resets to idle-high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bstate  <= B_IDLE;
      sync_ff <= 2'b11;
      rx_prev <= 1'b1;
      cnt     <= '0;
      bitn    <= '0;
      shreg   <= '0;
`ifdef UART_PARITY_EN
      perr    <= 1'b0;
`endif
    end else begin
      sync_ff <= {sync_ff[0], uart_data};
      rx_prev <= rx;
      case (bstate)
        B_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx) bstate <= B_START;
        end
        B_START: begin
          if (cnt == C_HALF) begin
            cnt    <= '0;
            bitn   <= '0;
            bstate <= rx ? B_IDLE : B_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt == C_LAST) begin
            cnt   <= '0;
            shreg <= {rx, shreg[7:1]};
            bitn  <= bitn + 1'b1;
`ifdef UART_PARITY_EN
            if (bitn == 3'd7) bstate <= B_PAR;
`else
            if (bitn == 3'd7) bstate <= B_STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        B_PAR: begin
          if (cnt == C_LAST) begin
            cnt    <= '0;
            perr   <= (rx != ^shreg);
            bstate <= B_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        B_STOP: begin
          if (cnt == C_LAST) begin
            cnt    <= '0;
            bstate <= B_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  // Packet assembler; par only changes on a checksum-verified commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pstate    <= P_WAIT;
      idx       <= '0;
      csum      <= '0;
      stage     <= '0;
      tcnt      <= '0;
      par       <= '0;
      par_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      par_valid <= 1'b0;
      frame_err <= 1'b0;
      if (pstate == P_WAIT || byte_ok) tcnt <= '0;
      else                             tcnt <= tcnt + 1'b1;
      case (pstate)
        P_WAIT: begin
          if (byte_bad) begin
            frame_err <= 1'b1;
          end else if (byte_ok && shreg == SYNC_BYTE) begin
            pstate <= P_PAYLOAD;
            busy   <= 1'b1;
            idx    <= '0;
            csum   <= '0;
          end
        end
        P_PAYLOAD, P_CHECK: begin
          if (byte_bad || timeout) begin
            pstate    <= P_WAIT;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else if (byte_ok) begin
            if (pstate == P_PAYLOAD) begin
              for (int j = 0; j < NBYTES; j++)
                if (idx == IW'(j)) stage[j*8 +: 8] <= shreg;
              csum <= csum + shreg;
              idx  <= idx + 1'b1;
              if (idx == IW'(NBYTES - 1)) pstate <= P_CHECK;
            end else begin
              if (shreg == csum) begin
                for (int k = 0; k < PAR_NUM; k++)
                  par[k*PAR_W +: PAR_W] <= stage[k*BPP*8 +: PAR_W];
                par_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              pstate <= P_WAIT;
              busy   <= 1'b0;
            end
          end
        end
        default: pstate <= P_WAIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_conf_loader.sv
//------------------------------------------------------------------------------
// tb_uart_conf_loader: randomized self-checking bench for uart_conf_loader.
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_conf_loader;

  localparam int BD  = 4;
  localparam int PN  = 2;
  localparam int PW  = 12;
  localparam int TB  = 32;
  localparam int BPP = (PW + 7) / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            uart_data;
  logic [PN*PW-1:0] par;
  logic            par_valid;
  logic            frame_err;
  logic            busy;

  int vec = 0;
  int err = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  logic [PN*PW-1:0] exp_par;
  logic [7:0] pkt[$];

  uart_conf_loader #(
    .BAUD_DIV(BD), .PAR_NUM(PN), .PAR_W(PW), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(TB)
  ) dut (
    .clk(clk), .rst(rst), .uart_data(uart_data), .par(par),
    .par_valid(par_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (par_valid) pv_cnt++;
      if (frame_err) fe_cnt++;
      if (par_valid && frame_err) both_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    uart_data = b;
    repeat (BD) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input logic par_flip);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_PARITY_EN
    bit_out((^b) ^ par_flip);
`else
    if (par_flip) uart_data = 1'b1;
`endif
    bit_out(stop_val);
    uart_data = 1'b1;
  endtask

  // Sends the queued packet; a corrupted byte ends the transmission.
  task automatic send_pkt(input int bad_stop, input int bad_par, input int gap);
    foreach (pkt[i]) begin
      send_byte(pkt[i], (i != bad_stop), (i == bad_par));
      if (i == bad_stop || i == bad_par) begin
        uart_data = 1'b1;
        repeat (3 * BD) tick();
        return;
      end
      repeat (gap * BD) tick();
    end
  endtask

  // Reference packet builder: little-endian bytes, junk above PW, sum mod 256.
  task automatic make_pkt(input logic [PN*PW-1:0] vals, input bit bad_sum);
    logic [PW-1:0] w;
    logic [7:0] b;
    logic [7:0] s;
    pkt.delete();
    pkt.push_back(8'hA5);
    s = 8'h00;
    for (int k = 0; k < PN; k++) begin
      w = vals[k*PW +: PW];
      for (int j = 0; j < BPP; j++) begin
        b = 8'(w >> (8 * j));
        if (8 * j + 8 > PW) b = b | 8'($urandom & (8'hFF << (PW - 8 * j)));
        pkt.push_back(b);
        s = s + b;
      end
    end
    if (bad_sum) s = s ^ (8'h01 << $urandom_range(0, 7));
    pkt.push_back(s);
  endtask

  task automatic test_reset();
    vec++; if (par !== '0) begin err++; $display("FAIL reset_par: got %h want %h", par, 24'h0); end
    vec++; if (par_valid !== 1'b0) begin err++; $display("FAIL reset_par_valid: got %b want 0", par_valid); end
    vec++; if (frame_err !== 1'b0) begin err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_bad_checksum();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    pkt = '{8'hA5, 8'h34, 8'h12, 8'hCD, 8'h0B, 8'h1F};
    send_pkt(-1, -1, 0);
    repeat (10) tick();
    vec++; if (fe_cnt - fe0 !== 1) begin err++; $display("FAIL badsum_fe: got %0d want 1", fe_cnt - fe0); end
    vec++; if (pv_cnt - pv0 !== 0) begin err++; $display("FAIL badsum_pv: got %0d want 0", pv_cnt - pv0); end
    vec++; if (par !== 24'h0) begin err++; $display("FAIL badsum_par: got %h want %h", par, 24'h0); end
  endtask

  task automatic test_spec_vector();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'hA5, 1'b1, 1'b0);
    repeat (3) tick();
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL spec_busy_high: got %b want 1", busy); end
    pkt = '{8'h34, 8'h12, 8'hCD, 8'h0B, 8'h1E};
    send_pkt(-1, -1, 0);
    repeat (10) tick();
    exp_par = {12'hBCD, 12'h234};
    vec++; if (pv_cnt - pv0 !== 1) begin err++; $display("FAIL spec_pv: got %0d want 1", pv_cnt - pv0); end
    vec++; if (fe_cnt - fe0 !== 0) begin err++; $display("FAIL spec_fe: got %0d want 0", fe_cnt - fe0); end
    vec++; if (par !== exp_par) begin err++; $display("FAIL spec_par: got %h want %h", par, exp_par); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL spec_busy_low: got %b want 0", busy); end
  endtask

  task automatic test_framing();
    int pv0, fe0;
    logic [PN*PW-1:0] v;
    v = PN*PW'($urandom);
    make_pkt(v, 1'b0);
    send_pkt(-1, -1, 1);
    repeat (10) tick();
    exp_par = v;
    vec++; if (par !== exp_par) begin err++; $display("FAIL frm_first_par: got %h want %h", par, exp_par); end
    pv0 = pv_cnt; fe0 = fe_cnt;
    make_pkt(PN*PW'($urandom), 1'b0);
    send_pkt(3, -1, 0);
    vec++; if (fe_cnt - fe0 !== 1) begin err++; $display("FAIL frm_fe: got %0d want 1", fe_cnt - fe0); end
    vec++; if (pv_cnt - pv0 !== 0) begin err++; $display("FAIL frm_pv: got %0d want 0", pv_cnt - pv0); end
    vec++; if (par !== exp_par) begin err++; $display("FAIL frm_par_kept: got %h want %h", par, exp_par); end
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    send_pkt(-1, -1, 0);
    repeat (10) tick();
    exp_par = {12'h002, 12'h001};
    vec++; if (par !== exp_par) begin err++; $display("FAIL frm_after_par: got %h want %h", par, exp_par); end
  endtask

  task automatic test_glitch_junk();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    uart_data = 1'b0; tick(); uart_data = 1'b1;
    repeat (4 * BD) tick();
    pkt = '{8'h00, 8'hFF};
    send_pkt(-1, -1, 1);
    repeat (10) tick();
    vec++; if (fe_cnt - fe0 !== 0) begin err++; $display("FAIL glitch_fe: got %0d want 0", fe_cnt - fe0); end
    vec++; if (pv_cnt - pv0 !== 0) begin err++; $display("FAIL glitch_pv: got %0d want 0", pv_cnt - pv0); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL glitch_busy: got %b want 0", busy); end
    exp_par = PN*PW'($urandom);
    make_pkt(exp_par, 1'b0);
    send_pkt(-1, -1, 0);
    repeat (10) tick();
    vec++; if (pv_cnt - pv0 !== 1) begin err++; $display("FAIL glitch_commit_pv: got %0d want 1", pv_cnt - pv0); end
    vec++; if (par !== exp_par) begin err++; $display("FAIL glitch_commit_par: got %h want %h", par, exp_par); end
  endtask

  task automatic test_timeout();
    int fe0, waited;
    fe0 = fe_cnt;
    pkt = '{8'hA5, 8'h34};
    send_pkt(-1, -1, 0);
    waited = 0;
    while (fe_cnt == fe0 && waited < 40 * BD) begin
      tick();
      waited++;
    end
    vec++; if (waited < TB * BD - 8 || waited > TB * BD + 12) begin
      err++; $display("FAIL timeout_delay: got %0d cycles want about %0d", waited, TB * BD);
    end
    tick();
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL timeout_busy: got %b want 0", busy); end
    vec++; if (par !== exp_par) begin err++; $display("FAIL timeout_par: got %h want %h", par, exp_par); end
  endtask

  task automatic test_reset_mid();
    int pv0;
    pkt = '{8'hA5, 8'h34};
    send_pkt(-1, -1, 0);
    uart_data = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    vec++; if (par !== '0) begin err++; $display("FAIL rstmid_par: got %h want 0", par); end
    vec++; if (par_valid !== 1'b0) begin err++; $display("FAIL rstmid_pv: got %b want 0", par_valid); end
    vec++; if (frame_err !== 1'b0) begin err++; $display("FAIL rstmid_fe: got %b want 0", frame_err); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    uart_data = 1'b1;
    repeat (60) tick();
    pv0 = pv_cnt;
    exp_par = PN*PW'($urandom);
    make_pkt(exp_par, 1'b0);
    send_pkt(-1, -1, 0);
    repeat (10) tick();
    vec++; if (pv_cnt - pv0 !== 1) begin err++; $display("FAIL rstmid_commit_pv: got %0d want 1", pv_cnt - pv0); end
    vec++; if (par !== exp_par) begin err++; $display("FAIL rstmid_commit_par: got %h want %h", par, exp_par); end
  endtask

  task automatic test_random();
    int pv0, fe0;
    logic [PN*PW-1:0] v;
    bit bad;
    for (int n = 0; n < 8; n++) begin
      pv0 = pv_cnt; fe0 = fe_cnt;
      v   = PN*PW'($urandom);
      bad = ($urandom_range(0, 2) == 0);
      make_pkt(v, bad);
      send_pkt(-1, -1, $urandom_range(0, 3));
      repeat (10) tick();
      if (!bad) exp_par = v;
      vec++; if (pv_cnt - pv0 !== (bad ? 0 : 1)) begin err++; $display("FAIL rand_pv[%0d]: got %0d want %0d", n, pv_cnt - pv0, bad ? 0 : 1); end
      vec++; if (fe_cnt - fe0 !== (bad ? 1 : 0)) begin err++; $display("FAIL rand_fe[%0d]: got %0d want %0d", n, fe_cnt - fe0, bad ? 1 : 0); end
      vec++; if (par !== exp_par) begin err++; $display("FAIL rand_par[%0d]: got %h want %h", n, par, exp_par); end
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    exp_par = PN*PW'($urandom);
    make_pkt(exp_par, 1'b0);
    send_pkt(-1, -1, 0);
    repeat (10) tick();
    vec++; if (pv_cnt - pv0 !== 1) begin err++; $display("FAIL parity_good_pv: got %0d want 1", pv_cnt - pv0); end
    vec++; if (par !== exp_par) begin err++; $display("FAIL parity_good_par: got %h want %h", par, exp_par); end
    pv0 = pv_cnt; fe0 = fe_cnt;
    make_pkt(PN*PW'($urandom), 1'b0);
    send_pkt(-1, 2, 0);
    vec++; if (fe_cnt - fe0 !== 1) begin err++; $display("FAIL parity_bad_fe: got %0d want 1", fe_cnt - fe0); end
    vec++; if (par !== exp_par) begin err++; $display("FAIL parity_bad_par: got %h want %h", par, exp_par); end
  endtask
`endif

  task automatic test_exclusive();
    vec++; if (both_cnt !== 0) begin err++; $display("FAIL pv_fe_overlap: got %0d cycles want 0", both_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    uart_data = 1'b1;
    exp_par = '0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_bad_checksum();
    test_spec_vector();
    test_framing();
    test_glitch_junk();
    test_timeout();
    test_reset_mid();
    test_random();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

`default_nettype wire
